// File: rtl/icache_pkg.sv
// Shared widths and FSM state encodings for the instruction cache.
// Imported by icache and icache_array.
package icache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE    = 2'd0,
    ICACHE_FETCH   = 2'd1,
    ICACHE_DISCARD = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// One combinational read port, one synchronous write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_W      = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic [TAG_W-1:0]      wtag,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  input  logic [INDEX_BITS-1:0] ridx,
  output logic                  rvalid,
  output logic [TAG_W-1:0]      rtag,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [WORD_WIDTH-1:0] data_q [LINES];

  // Valid bits: cleared by reset or flush, set/cleared by a fill.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= wvalid;
    end
  end

  // Tag and data lines are written on fill and never reset.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line icache between IF and memory controller.
// Define ICACHE_FLUSH_EN to add the iCache_flush invalidate-all port.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob2iCache_clear,
`ifdef ICACHE_FLUSH_EN
  input  logic                  iCache_flush,
`endif
  input  logic                  if2iCache_valid,
  input  logic [ADDR_W-1:0]     if2iCache_addr,
  output logic                  iCache2if_ready,
  output logic [WORD_WIDTH-1:0] iCache2if_inst,
  output logic                  iCache2memCon_valid,
  output logic [ADDR_W-1:0]     iCache2memCon_adderss,
  input  logic [WORD_WIDTH-1:0] memCon2iCache_return,
  input  logic                  memCon2iCache_done,
  input  logic                  memCon2iCache_ifbusy
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  icache_state_e state_q;
  logic          kill_q;

  logic                  flush;
  logic                  abort;
  logic                  hit;
  logic                  we;
  logic                  wvalid;
  logic                  rvalid;
  logic [INDEX_BITS-1:0] ridx;
  logic [INDEX_BITS-1:0] widx;
  logic [TAG_W-1:0]      req_tag;
  logic [TAG_W-1:0]      rtag;
  logic [TAG_W-1:0]      wtag;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  unused_in;

`ifdef ICACHE_FLUSH_EN
  assign flush = iCache_flush;
`else
  assign flush = 1'b0;
`endif

  // The controller holds the request itself while busy.
  assign unused_in = ^{memCon2iCache_ifbusy, if2iCache_addr[1:0]};

  assign ridx    = if2iCache_addr[INDEX_BITS+1:2];
  assign req_tag = if2iCache_addr[ADDR_W-1:INDEX_BITS+2];
  assign widx    = iCache2memCon_adderss[INDEX_BITS+1:2];
  assign wtag    = iCache2memCon_adderss[ADDR_W-1:INDEX_BITS+2];
  assign hit     = rvalid && (rtag == req_tag);
  assign abort   = rob2iCache_clear || flush;
  assign we      = rdy_in && memCon2iCache_done
                && (state_q != ICACHE_IDLE);
  assign wvalid  = !(kill_q || flush);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (rdy_in && flush),
    .we     (we),
    .widx   (widx),
    .wtag   (wtag),
    .wdata  (memCon2iCache_return),
    .wvalid (wvalid),
    .ridx   (ridx),
    .rvalid (rvalid),
    .rtag   (rtag),
    .rdata  (rdata)
  );

  // Request FSM: hit return, miss fetch, and discard after a flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q               <= ICACHE_IDLE;
      kill_q                <= 1'b0;
      iCache2if_ready       <= 1'b0;
      iCache2if_inst        <= '0;
      iCache2memCon_valid   <= 1'b0;
      iCache2memCon_adderss <= '0;
    end else if (rdy_in) begin
      iCache2if_ready <= 1'b0;
      unique case (state_q)
        ICACHE_IDLE: begin
          if (if2iCache_valid && !iCache2if_ready && !abort) begin
            if (hit) begin
              iCache2if_ready <= 1'b1;
              iCache2if_inst  <= rdata;
            end else begin
              iCache2memCon_adderss <= {if2iCache_addr[ADDR_W-1:2], 2'b00};
              iCache2memCon_valid   <= 1'b1;
              kill_q                <= 1'b0;
              state_q               <= ICACHE_FETCH;
            end
          end
        end
        ICACHE_FETCH: begin
          if (memCon2iCache_done) begin
            iCache2memCon_valid <= 1'b0;
            state_q             <= ICACHE_IDLE;
            if (!abort) begin
              iCache2if_ready <= 1'b1;
              iCache2if_inst  <= memCon2iCache_return;
            end
          end else if (abort) begin
            state_q <= ICACHE_DISCARD;
          end
        end
        ICACHE_DISCARD: begin
          if (memCon2iCache_done) begin
            iCache2memCon_valid <= 1'b0;
            state_q             <= ICACHE_IDLE;
          end
        end
        default: state_q <= ICACHE_IDLE;
      endcase
      if (flush && (state_q != ICACHE_IDLE)) begin
        kill_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: line-level cache model plus
// a scripted memory controller and directed request scenarios.
module tb_icache;
  import icache_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clr    = 1'b0;
  logic        req_v  = 1'b0;
  logic [31:0] req_a  = '0;
  logic        ready;
  logic [31:0] inst;
  logic        mv;
  logic [31:0] ma;
  logic [31:0] ret    = '0;
  logic        done   = 1'b0;
  logic        busy   = 1'b0;
`ifdef ICACHE_FLUSH_EN
  logic        flush  = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  icache dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .rob2iCache_clear      (clr),
`ifdef ICACHE_FLUSH_EN
    .iCache_flush          (flush),
`endif
    .if2iCache_valid       (req_v),
    .if2iCache_addr        (req_a),
    .iCache2if_ready       (ready),
    .iCache2if_inst        (inst),
    .iCache2memCon_valid   (mv),
    .iCache2memCon_adderss (ma),
    .memCon2iCache_return  (ret),
    .memCon2iCache_done    (done),
    .memCon2iCache_ifbusy  (busy)
  );

  // Cache-content model: which tag each of the 256 lines holds.
  bit          mvld [256];
  logic [21:0] mtag [256];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_1000) return 32'h0000_0013;
    return {w[15:0], 16'h0093};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvld[a[9:2]] && (mtag[a[9:2]] == a[31:10]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Scripted memory controller: busy phase, then done after lat cycles.
  int lat = 5;
  int busy_left = 0;
  int cnt = 0;
  int fills = 0;
  always @(posedge clk_in) begin
    #1;
    done = 1'b0;
    if (!rst_in || !mv) begin
      cnt = 0;
    end else if (rdy_in) begin
      if (busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else begin
        busy = 1'b0;
        cnt++;
        if (cnt >= lat) begin
          done  = 1'b1;
          ret   = mem_word(ma);
          cnt   = 0;
          fills++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  logic [31:0] exp_fetch = '0;
  logic [31:0] prev_ma = '0;
  logic        prev_mv = 1'b0;
  bit          no_ready = 1'b0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (ready) begin
        chk("inst_model", inst, mem_word(req_a));
        if (no_ready) chk("ready_suppressed", 32'(ready), 32'd0);
      end
      if (mv) begin
        chk("mem_addr", ma, exp_fetch);
        if (prev_mv) chk("mem_addr_stable", ma, prev_ma);
      end
      if (done && mv) begin
        mvld[ma[9:2]] = 1'b1;
        mtag[ma[9:2]] = ma[31:10];
      end
    end
    prev_mv = mv;
    prev_ma = ma;
  end

  task automatic fetch(input logic [31:0] a, input bit exp_hit,
                       input int exp_lat);
    int n;
    int f0;
    bit saw_mv;
    n = 0;
    f0 = fills;
    saw_mv = 1'b0;
    chk("model_hit", 32'(model_hit(a)), 32'(exp_hit));
    exp_fetch = {a[31:2], 2'b00};
    @(posedge clk_in); #1;
    req_a = a;
    req_v = 1'b1;
    do begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
      if (mv) saw_mv = 1'b1;
    end while (!ready && n < 200);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("mem_request", 32'(saw_mv), 32'(!exp_hit));
    chk("fill_count", 32'(fills - f0), exp_hit ? 32'd0 : 32'd1);
    chk("ready_inst", inst, mem_word(a));
    @(posedge clk_in); #1;
    req_v = 1'b0;
    @(negedge clk_in);
    chk("ready_single", 32'(ready), 32'd0);
  endtask

  initial begin
    int k;
    int f0;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int f0;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_mvalid", 32'(mv), 32'd0);
    chk("rst_maddr", ma, 32'd0);
    rst_in = 1'b1;

    // Cold miss, hit, ignored low bits, conflict misses.
    lat = 5;
    fetch(32'h0000_1000, 1'b0, 6);
    chk("inst_literal", inst, 32'h0000_0013);
    fetch(32'h0000_1000, 1'b1, 1);
    fetch(32'h0000_1002, 1'b1, 1);
    fetch(32'h0000_1400, 1'b0, 6);
    fetch(32'h0000_1000, 1'b0, 6);

    // Clear together with a hit in IDLE: no return.
    @(posedge clk_in); #1;
    req_a = 32'h0000_1000;
    req_v = 1'b1;
    clr = 1'b1;
    no_ready = 1'b1;
    @(posedge clk_in); #1;
    clr = 1'b0;
    req_v = 1'b0;
    @(negedge clk_in);
    chk("clear_hit", 32'(ready), 32'd0);
    no_ready = 1'b0;

    // Clear two cycles into a miss: request held, fill, no return.
    lat = 6;
    f0 = fills;
    exp_fetch = 32'h0000_2000;
    @(posedge clk_in); #1;
    req_a = 32'h0000_2000;
    req_v = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    clr = 1'b1;
    req_v = 1'b0;
    no_ready = 1'b1;
    @(posedge clk_in); #1;
    clr = 1'b0;
    @(negedge clk_in);
    chk("discard_hold", 32'(mv), 32'd1);
    k = 0;
    while (fills == f0 && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    repeat (3) @(negedge clk_in);
    chk("discard_release", 32'(mv), 32'd0);
    chk("discard_fill", 32'(fills - f0), 32'd1);
    no_ready = 1'b0;
    lat = 5;
    fetch(32'h0000_2000, 1'b1, 1);

    // Controller busy for 10 cycles, then 2-cycle return.
    lat = 2;
    busy_left = 10;
    fetch(32'h0000_3000, 1'b0, 13);
    lat = 5;

    // rdy_in low stretches the ready pulse.
    @(posedge clk_in); #1;
    req_a = 32'h0000_3000;
    req_v = 1'b1;
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("rdy_hold", 32'(ready), 32'd1);
    end
    @(posedge clk_in); #1;
    rdy_in = 1'b1;
    @(posedge clk_in); #1;
    req_v = 1'b0;
    @(negedge clk_in);
    chk("rdy_release", 32'(ready), 32'd0);

    // Asynchronous reset in the middle of a fetch.
    lat = 20;
    exp_fetch = 32'h0000_4000;
    @(posedge clk_in); #1;
    req_a = 32'h0000_4000;
    req_v = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("pre_reset_mvalid", 32'(mv), 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_mvalid", 32'(mv), 32'd0);
    chk("arst_maddr", ma, 32'd0);
    chk("arst_inst", inst, 32'd0);
    req_v = 1'b0;
    foreach (mvld[i]) mvld[i] = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    lat = 5;
    fetch(32'h0000_3000, 1'b0, 6);

`ifdef ICACHE_FLUSH_EN
    fetch(32'h0000_3000, 1'b1, 1);
    @(posedge clk_in); #1;
    flush = 1'b1;
    @(posedge clk_in); #1;
    flush = 1'b0;
    foreach (mvld[i]) mvld[i] = 1'b0;
    fetch(32'h0000_3000, 1'b0, 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
